pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Produces the per-stage stall/flush controls consumed by the IF/ID and ID/EX pipeline registers and the PC.
//  Detects load-use hazards (EX load feeding an ID source) and tracks outstanding I/D cache misses.
//  Applies EX-resolved branch redirects; a redirect arriving during a cache stall is deferred and replayed when the stall ends.
//  Keeps stall/flush performance counters and a sticky cache-timeout flag.
// PARAMETERS
//  CNT_W        32    width of perf counters (saturating)
//  TIMEOUT_CYC  1024  consecutive CWAIT cycles before timeout_err sets
// PORTS
//  clk               in   1      rising-edge clock; only clock
//  rst               in   1      synchronous, active-high reset
//  id_rs1_addr       in   5      ID-stage rs1 index
//  id_rs2_addr       in   5      ID-stage rs2 index
//  id_rs1_valid      in   1      ID instr reads rs1
//  id_rs2_valid      in   1      ID instr reads rs2
//  ex_valid          in   1      EX holds a real instruction
//  ex_rd_addr        in   5      EX destination index
//  ex_rd_valid       in   1      EX writes rd
//  ex_opcode         in   7      EX opcode (load = OPC_LOAD)
//  branch_taken      in   1      EX resolved a taken branch/jump this cycle
//  branch_target     in   32     redirect PC, valid with branch_taken
//  icache_miss       in   1      I-cache miss starts (pulse or level)
//  icache_ready      in   1      I-cache refill complete
//  dcache_miss       in   1      D-cache miss starts
//  dcache_ready      in   1      D-cache refill complete
//  pc_stall          out  1      hold PC
//  if_id_stall       out  1      hold IF/ID contents
//  if_id_flush       out  1      squash IF/ID
//  hazard_stall      out  1      ID/EX inserts bubble (load-use)
//  flush             out  1      ID/EX inserts bubble (redirect)
//  cache_stall       out  1      ID/EX bubble; front end frozen
//  redirect_valid    out  1      load PC with redirect_pc this cycle
//  redirect_pc       out  32     redirect target
//  stall_cycles      out  CNT_W  cycles with any stall asserted
//  flush_count       out  CNT_W  redirects applied
//  timeout_err       out  1      sticky; cleared only by rst
// BEHAVIOUR
//  - Reset: while rst=1, all outputs 0, state=RUN, miss flags/pending cleared.
//  - Control outputs are combinational from state + inputs, so they take effect in the same cycle.
//  - Miss flags: imiss_n = (imiss|icache_miss) & ~icache_ready; dmiss_n likewise.
//    A miss and its ready arriving in the same cycle cause no stall.
//  - cache_stall = imiss_n|dmiss_n; while it is 1, pc_stall=if_id_stall=1 and redirect_valid=0.
//  - Load-use: lu = ex_valid & ex_rd_valid & ex_rd_addr!=0 & ex_opcode==OPC_LOAD &
//    ((id_rs1_valid & rs1==rd) | (id_rs2_valid & rs2==rd)).
//  - Priority: cache_stall > redirect > load-use.
//    * Redirect (branch_taken in RUN, no cache stall): flush=if_id_flush=redirect_valid=1,
//      redirect_pc=branch_target, hazard_stall=0, pc_stall=0.
//    * Load-use only: hazard_stall=pc_stall=if_id_stall=1 for exactly 1 cycle.
//  - FSM:
//    * RUN -> CWAIT when cache_stall.
//    * CWAIT -> RUN when both miss flags clear and no pending redirect.
//    * CWAIT -> REPLAY when both miss flags clear and a redirect is pending.
//    * REPLAY -> RUN after 1 cycle. REPLAY drives flush, if_id_flush, redirect_valid=1 with redirect_pc=pend_pc.
//  - branch_taken while cache_stall: set pend=1, pend_pc=branch_target.
//    A later branch_taken in the same stall overwrites pend_pc (youngest-resolved wins).
//  - Stall ends in the same cycle branch_taken arrives (flags clear): apply the redirect directly; no REPLAY.
//  - branch_taken during REPLAY is ignored (EX holds a bubble there).
//  - stall_cycles += 1 when cache_stall|hazard_stall; flush_count += 1 when redirect_valid.
//    Both counters saturate at all-ones.
//  - wait_cnt counts CWAIT cycles and clears on leaving CWAIT; reaching TIMEOUT_CYC sets timeout_err.
//    The FSM keeps waiting.
// STRUCTURE
//  - Shared include pipeline_defs.vh: OPC_LOAD=7'b0000011, state encodings S_RUN/S_CWAIT/S_REPLAY (2 bits).
//  - Sub-module load_use_detect (combinational lu compare).
//  - FSM, miss flags, pending redirect and counters stay in the top.
// TESTING
//  - ex lw rd=x5, id rs1=x5 valid -> hazard_stall=pc_stall=1 for 1 cycle; rd=x0 -> no stall.
//  - branch_taken, target 0x100 in RUN -> same cycle flush=if_id_flush=redirect_valid=1, pc=0x100; flush_count=1.
//  - icache_miss @t0, icache_ready @t0+5 -> cache_stall=1 t0..t0+4, 0 at t0+5; stall_cycles=5.
//  - dcache_miss @t0, branch 0x200 @t0+2, ready @t0+6 -> REPLAY @t0+6: redirect_valid=1, pc=0x200.
//  - icache_miss & icache_ready same cycle -> cache_stall=0; TIMEOUT_CYC=8, no ready -> timeout_err=1 after 8 CWAIT cycles.
//  - rst asserted mid-CWAIT with pend=1 -> next cycle all outputs 0, state RUN, no REPLAY.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared opcode and FSM state definitions for the hazard controller
package pipeline_hazard_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD = 7'b0000011;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_CWAIT  = 2'd1,
    S_REPLAY = 2'd2
  } state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// rtl/pipeline_hazard_ctrl_load_use_detect.sv - combinational load-use compare between EX load and ID sources
module load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [4:0] i_id_rs1_addr,
  input  logic [4:0] i_id_rs2_addr,
  input  logic       i_id_rs1_valid,
  input  logic       i_id_rs2_valid,
  input  logic       i_ex_valid,
  input  logic [4:0] i_ex_rd_addr,
  input  logic       i_ex_rd_valid,
  input  logic [6:0] i_ex_opcode,
  output logic       o_lu
);

  logic w_ex_load;
  logic w_src_hit;

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign w_ex_load = i_ex_valid & i_ex_rd_valid & (i_ex_rd_addr != 5'd0) &
                     (i_ex_opcode == OPC_LOAD);
  assign w_src_hit = (i_id_rs1_valid & (i_id_rs1_addr == i_ex_rd_addr)) |
                     (i_id_rs2_valid & (i_id_rs2_addr == i_ex_rd_addr));
  assign o_lu      = w_ex_load & w_src_hit;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush control with cache-miss tracking, deferred redirect replay and perf counters
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_rs1_valid,
  input  logic             id_rs2_valid,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_rd_valid,
  input  logic [6:0]       ex_opcode,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             icache_miss,
  input  logic             icache_ready,
  input  logic             dcache_miss,
  input  logic             dcache_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             hazard_stall,
  output logic             flush,
  output logic             cache_stall,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             timeout_err
);

  localparam int                WAIT_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WAIT_W-1:0] TO_LAST = WAIT_W'(TIMEOUT_CYC - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_imiss;
  logic              r_dmiss;
  logic              r_pend;
  logic [31:0]       r_pend_pc;
  logic [CNT_W-1:0]  r_stall_cycles;
  logic [CNT_W-1:0]  r_flush_count;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_timeout;

  logic        w_imiss_n;
  logic        w_dmiss_n;
  logic        w_cache_stall;
  logic        w_lu;
  logic        w_pend_set;
  logic        w_pc_stall;
  logic        w_if_id_stall;
  logic        w_if_id_flush;
  logic        w_hazard_stall;
  logic        w_flush;
  logic        w_redirect_valid;
  logic [31:0] w_redirect_pc;

  // A ready in the same cycle as its miss cancels it outright
  assign w_imiss_n     = (r_imiss | icache_miss) & ~icache_ready;
  assign w_dmiss_n     = (r_dmiss | dcache_miss) & ~dcache_ready;
  assign w_cache_stall = w_imiss_n | w_dmiss_n;

  load_use_detect u_lu (
    .i_id_rs1_addr (id_rs1_addr),
    .i_id_rs2_addr (id_rs2_addr),
    .i_id_rs1_valid(id_rs1_valid),
    .i_id_rs2_valid(id_rs2_valid),
    .i_ex_valid    (ex_valid),
    .i_ex_rd_addr  (ex_rd_addr),
    .i_ex_rd_valid (ex_rd_valid),
    .i_ex_opcode   (ex_opcode),
    .o_lu          (w_lu)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_pend_set       = 1'b0;
    w_pc_stall       = 1'b0;
    w_if_id_stall    = 1'b0;
    w_if_id_flush    = 1'b0;
    w_hazard_stall   = 1'b0;
    w_flush          = 1'b0;
    w_redirect_valid = 1'b0;
    w_redirect_pc    = '0;

    if (w_cache_stall) begin
      w_pc_stall    = 1'b1;
      w_if_id_stall = 1'b1;
      w_pend_set    = branch_taken & (r_state != S_REPLAY);
    end else if (r_state == S_REPLAY) begin
      w_flush          = 1'b1;
      w_if_id_flush    = 1'b1;
      w_redirect_valid = 1'b1;
      w_redirect_pc    = r_pend_pc;
    end else if (branch_taken) begin
      w_flush          = 1'b1;
      w_if_id_flush    = 1'b1;
      w_redirect_valid = 1'b1;
      w_redirect_pc    = branch_target;
    end else if (w_lu) begin
      w_hazard_stall = 1'b1;
      w_pc_stall     = 1'b1;
      w_if_id_stall  = 1'b1;
    end

    case (r_state)
      S_RUN:    if (w_cache_stall) w_state_nxt = S_CWAIT;
      // A branch landing on the stall-release cycle is younger than any pending one
      S_CWAIT:  if (!w_cache_stall) w_state_nxt = (r_pend && !branch_taken) ? S_REPLAY : S_RUN;
      S_REPLAY: w_state_nxt = w_cache_stall ? S_CWAIT : S_RUN;
      default:  w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_RUN;
      r_imiss        <= 1'b0;
      r_dmiss        <= 1'b0;
      r_pend         <= 1'b0;
      r_pend_pc      <= '0;
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
      r_wait_cnt     <= '0;
      r_timeout      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_imiss <= w_imiss_n;
      r_dmiss <= w_dmiss_n;
      if (w_pend_set) begin
        r_pend    <= 1'b1;
        r_pend_pc <= branch_target;
      end else if (w_redirect_valid) begin
        r_pend <= 1'b0;
      end
      if ((w_cache_stall | w_hazard_stall) && (r_stall_cycles != {CNT_W{1'b1}}))
        r_stall_cycles <= r_stall_cycles + 1'b1;
      if (w_redirect_valid && (r_flush_count != {CNT_W{1'b1}}))
        r_flush_count <= r_flush_count + 1'b1;
      if (r_state == S_CWAIT && w_state_nxt == S_CWAIT) begin
        if (r_wait_cnt != TO_LAST) r_wait_cnt <= r_wait_cnt + 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end
      if (r_state == S_CWAIT && r_wait_cnt == TO_LAST) r_timeout <= 1'b1;
    end
  end

  assign pc_stall       = ~rst & w_pc_stall;
  assign if_id_stall    = ~rst & w_if_id_stall;
  assign if_id_flush    = ~rst & w_if_id_flush;
  assign hazard_stall   = ~rst & w_hazard_stall;
  assign flush          = ~rst & w_flush;
  assign cache_stall    = ~rst & w_cache_stall;
  assign redirect_valid = ~rst & w_redirect_valid;
  assign redirect_pc    = rst ? '0 : w_redirect_pc;
  assign stall_cycles   = rst ? '0 : r_stall_cycles;
  assign flush_count    = rst ? '0 : r_flush_count;
  assign timeout_err    = ~rst & r_timeout;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic             id_rs1_valid, id_rs2_valid, ex_valid, ex_rd_valid;
  logic [6:0]       ex_opcode;
  logic             branch_taken;
  logic [31:0]      branch_target;
  logic             icache_miss, icache_ready, dcache_miss, dcache_ready;
  logic             pc_stall, if_id_stall, if_id_flush, hazard_stall, flush, cache_stall;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic             timeout_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_valid(id_rs1_valid), .id_rs2_valid(id_rs2_valid),
    .ex_valid(ex_valid), .ex_rd_addr(ex_rd_addr), .ex_rd_valid(ex_rd_valid),
    .ex_opcode(ex_opcode), .branch_taken(branch_taken), .branch_target(branch_target),
    .icache_miss(icache_miss), .icache_ready(icache_ready),
    .dcache_miss(dcache_miss), .dcache_ready(dcache_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .hazard_stall(hazard_stall), .flush(flush), .cache_stall(cache_stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall_cycles(stall_cycles), .flush_count(flush_count), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_valid = 0; id_rs2_valid = 0;
    ex_valid = 0; ex_rd_addr = 0; ex_rd_valid = 0; ex_opcode = 0;
    branch_taken = 0; branch_target = 0;
    icache_miss = 0; icache_ready = 0; dcache_miss = 0; dcache_ready = 0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic load_use(input logic [4:0] rd, input logic [6:0] opc,
                          input logic [4:0] rs1, input logic v1,
                          input logic [4:0] rs2, input logic v2);
    clr();
    ex_valid = 1; ex_rd_valid = 1; ex_rd_addr = rd; ex_opcode = opc;
    id_rs1_addr = rs1; id_rs1_valid = v1; id_rs2_addr = rs2; id_rs2_valid = v2;
  endtask

  function automatic logic [6:0] ctl();
    return {pc_stall, if_id_stall, if_id_flush, hazard_stall, flush, cache_stall, redirect_valid};
  endfunction

  initial begin
    clr();
    rst = 1'b1;
    cyc(); icache_miss = 1; branch_taken = 1; branch_target = 32'hdead;
    smp();
    chk("rst_ctl", ctl(), 7'd0);
    chk("rst_pc", redirect_pc, 0);
    chk("rst_cnt", {stall_cycles, flush_count, timeout_err}, 0);

    cyc(); rst = 1'b0; clr();
    smp();
    chk("idle_ctl", ctl(), 7'd0);

    // load-use patterns; stall_cycles accumulates 2
    cyc(); load_use(5'd5, 7'b0000011, 5'd5, 1, 5'd0, 0); smp();
    chk("lu_rs1_ctl", ctl(), 7'b1101000);
    cyc(); clr(); smp();
    chk("lu_one_cycle", hazard_stall, 0);
    chk("lu_cnt1", stall_cycles, 1);
    cyc(); load_use(5'd0, 7'b0000011, 5'd0, 1, 5'd0, 1); smp();
    chk("lu_x0", hazard_stall, 0);
    cyc(); load_use(5'd7, 7'b0110011, 5'd1, 1, 5'd7, 1); smp();
    chk("lu_not_load", hazard_stall, 0);
    cyc(); load_use(5'd7, 7'b0000011, 5'd1, 1, 5'd7, 1); smp();
    chk("lu_rs2", {hazard_stall, pc_stall}, 2'b11);
    cyc(); load_use(5'd7, 7'b0000011, 5'd1, 1, 5'd7, 0); smp();
    chk("lu_rs2_unused", hazard_stall, 0);
    cyc(); clr(); smp();
    chk("lu_cnt2", stall_cycles, 2);

    // redirect in RUN overrides a simultaneous load-use
    cyc(); load_use(5'd5, 7'b0000011, 5'd5, 1, 5'd0, 0);
    branch_taken = 1; branch_target = 32'h100; smp();
    chk("br_ctl", ctl(), 7'b0010101);
    chk("br_pc", redirect_pc, 32'h100);
    cyc(); clr(); smp();
    chk("br_cnt", flush_count, 1);
    chk("br_done", redirect_valid, 0);

    // I-miss for 5 cycles
    cyc(); icache_miss = 1; smp();
    chk("im_t0", ctl(), 7'b1100010);
    for (int k = 1; k < 5; k++) begin
      cyc(); clr(); smp();
      chk("im_hold", cache_stall, 1);
    end
    cyc(); icache_ready = 1; smp();
    chk("im_ready", ctl(), 7'd0);
    cyc(); clr(); smp();
    chk("im_cnt", stall_cycles, 7);

    // D-miss with two redirects during the stall; youngest is replayed
    cyc(); dcache_miss = 1; smp();
    chk("dm_t0", cache_stall, 1);
    cyc(); clr(); smp();
    cyc(); branch_taken = 1; branch_target = 32'h180; smp();
    chk("dm_br_held", {redirect_valid, flush, cache_stall}, 3'b001);
    cyc(); branch_taken = 1; branch_target = 32'h200; smp();
    cyc(); clr(); smp();
    cyc(); smp();
    cyc(); dcache_ready = 1; smp();
    chk("dm_ready", {cache_stall, redirect_valid}, 2'b00);
    cyc(); clr(); branch_taken = 1; branch_target = 32'h999; smp();
    chk("replay_ctl", ctl(), 7'b0010101);
    chk("replay_pc", redirect_pc, 32'h200);
    cyc(); clr(); smp();
    chk("replay_done", redirect_valid, 0);
    chk("replay_cnt", {stall_cycles, flush_count}, {8'd13, 8'd2});

    // miss and ready in the same cycle never stall
    cyc(); icache_miss = 1; icache_ready = 1; smp();
    chk("same_cyc", cache_stall, 0);
    cyc(); clr(); smp();
    chk("same_cyc_after", cache_stall, 0);

    // branch on the stall-release cycle is applied directly
    cyc(); dcache_miss = 1; smp();
    cyc(); clr(); dcache_ready = 1; branch_taken = 1; branch_target = 32'h300; smp();
    chk("direct_ctl", {cache_stall, redirect_valid}, 2'b01);
    chk("direct_pc", redirect_pc, 32'h300);
    cyc(); clr(); smp();
    chk("direct_no_replay", redirect_valid, 0);
    chk("direct_cnt", {stall_cycles, flush_count}, {8'd14, 8'd3});

    // timeout after 8 CWAIT cycles, with a redirect left pending
    cyc(); icache_miss = 1; smp();
    for (int k = 1; k <= 8; k++) begin
      cyc(); clr();
      if (k == 3) begin branch_taken = 1; branch_target = 32'h400; end
      smp();
      if (k == 8) chk("to_before", timeout_err, 0);
    end
    cyc(); clr(); smp();
    chk("to_set", timeout_err, 1);
    chk("to_waiting", cache_stall, 1);
    for (int k = 0; k < 260; k++) begin
      cyc(); smp();
    end
    chk("stall_sat", stall_cycles, 8'hff);

    // reset mid-CWAIT discards the pending redirect
    cyc(); rst = 1'b1; smp();
    chk("mid_rst_ctl", ctl(), 7'd0);
    cyc(); rst = 1'b0; smp();
    chk("post_rst_ctl", ctl(), 7'd0);
    chk("post_rst_regs", {stall_cycles, flush_count, timeout_err}, 0);
    cyc(); smp();
    chk("post_rst_no_replay", redirect_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
